// File: rtl/ifq_pkg.sv
// Shared definitions for the instruction fetch queue and the compute unit:
// opcodes, instruction field positions and the byte-assembler state encoding.
package ifq_pkg;

  localparam int INSTR_W = 16;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LOAD = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_NOT  = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;

  // imm overlaps src0/src1; which one applies depends on the opcode
  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 12;
  localparam int TGT_MSB  = 11;
  localparam int TGT_LSB  = 8;
  localparam int SRC0_MSB = 7;
  localparam int SRC0_LSB = 4;
  localparam int SRC1_MSB = 3;
  localparam int SRC1_LSB = 0;
  localparam int IMM_MSB  = 7;
  localparam int IMM_LSB  = 0;

  typedef enum logic {
    ASM_HI = 1'b0,
    ASM_LO = 1'b1
  } asm_state_t;

  function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Instruction FIFO: storage, wrapping pointers and occupancy count.
// Flush beats push and pop; full/empty are told apart only by count.
module ifq_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic [AW:0]      count_next;
  logic             do_push;
  logic             do_pop;
  logic [DEPTH-1:0] we;

  assign do_push = push && !flush && (count_reg != FULL);
  assign do_pop  = pop  && !flush && (count_reg != '0);

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
      assign we[gi] = do_push && (wr_ptr_reg == AW'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (we[i]) mem_reg[i] <= push_data;
      end
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
    end
  end

  assign head  = mem_reg[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/instr_fetch_queue.sv
// Byte-serial instruction assembler feeding a FIFO toward the compute unit.
// Define IFQ_NOP_DROP_EN to discard completed NOPs instead of queueing them.
module instr_fetch_queue
  import ifq_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         byte_in,
  input  logic               byte_valid,
  output logic               byte_ready,
  input  logic               flush,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [AW:0]        count,
  output logic               illegal_seen
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
`ifdef IFQ_NOP_DROP_EN
  localparam bit NOP_DROP = 1'b1;
`else
  localparam bit NOP_DROP = 1'b0;
`endif

  asm_state_t         state_reg, state_next;
  logic [7:0]         hi_byte_reg, hi_byte_next;
  logic               illegal_reg, illegal_next;
  logic [INSTR_W-1:0] assembled;
  logic [3:0]         assembled_op;
  logic               byte_accept;
  logic               push;

  // Ready depends only on registered state, so a pop never frees the low byte early
  assign byte_ready   = (state_reg == ASM_HI) || (count != FULL);
  assign byte_accept  = byte_valid && byte_ready;
  assign assembled    = {hi_byte_reg, byte_in};
  assign assembled_op = opcode_of(assembled);

  always_comb begin
    state_next   = state_reg;
    hi_byte_next = hi_byte_reg;
    illegal_next = illegal_reg;
    push         = 1'b0;
    if (flush) begin
      state_next   = ASM_HI;
      hi_byte_next = '0;
      illegal_next = 1'b0;
    end else if (byte_accept) begin
      case (state_reg)
        ASM_HI: begin
          hi_byte_next = byte_in;
          state_next   = ASM_LO;
        end
        ASM_LO: begin
          state_next = ASM_HI;
          if (assembled_op[3]) illegal_next = 1'b1;
          push = !(NOP_DROP && (assembled_op == OP_NOP));
        end
        default: state_next = ASM_HI;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ASM_HI;
      hi_byte_reg <= '0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      hi_byte_reg <= hi_byte_next;
      illegal_reg <= illegal_next;
    end
  end

  ifq_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(INSTR_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .push     (push),
    .push_data(assembled),
    .pop      (instr_ready),
    .head     (instr_out),
    .count    (count)
  );

  assign instr_valid  = (count != '0);
  assign illegal_seen = illegal_reg;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: stimulus pushes expected instructions
// into a scoreboard queue, a negedge monitor checks every issued instruction.
module tb_instr_fetch_queue;

  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    byte_in = 8'h00;
  logic          byte_valid = 1'b0;
  logic          byte_ready;
  logic          flush = 1'b0;
  logic [15:0]   instr_out;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [AW:0]   count;
  logic          illegal_seen;

  int            tests = 0;
  int            fails = 0;
  logic [15:0]   exp_q [$];
  logic [15:0]   mon_exp;

  instr_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .flush       (flush),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .count       (count),
    .illegal_seen(illegal_seen)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: a handshake seen at negedge completes on the following posedge
  always @(negedge clk) begin
    if (rst_n && !flush && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL issue_unexpected: got %04h, expected nothing", instr_out);
      end else begin
        mon_exp = exp_q.pop_front();
        $display("[TB] issue %04h (expected %04h)", instr_out, mon_exp);
        check("issue_order", {16'h0, instr_out}, {16'h0, mon_exp});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    byte_in = b;
    byte_valid = 1'b1;
    while (!acc && n < 50) begin
      acc = byte_ready && !flush;
      @(posedge clk);
      #1;
      n++;
    end
    byte_valid = 1'b0;
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL byte_timeout: byte %02h not accepted, expected acceptance", b);
    end
  endtask

  task automatic send_instr(input logic [7:0] hi, input logic [7:0] lo, input bit pop_on_lo);
    send_byte(hi);
    if (pop_on_lo) instr_ready = 1'b1;
    send_byte(lo);
    if (pop_on_lo) instr_ready = 1'b0;
`ifdef IFQ_NOP_DROP_EN
    if (hi[7:4] != 4'h0) exp_q.push_back({hi, lo});
`else
    exp_q.push_back({hi, lo});
`endif
    $display("[TB] push %02h%02h", hi, lo);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    instr_ready = 1'b1;
    while (count != '0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    instr_ready = 1'b0;
    check({name, "_count"}, 32'(count), 32'd0);
    check({name, "_scoreboard_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_count"}, 32'(count), 32'd0);
    check({name, "_byte_ready"}, 32'(byte_ready), 32'd1);
    check({name, "_instr_valid"}, 32'(instr_valid), 32'd0);
    check({name, "_instr_out"}, 32'(instr_out), 32'h0000);
    check({name, "_illegal_seen"}, 32'(illegal_seen), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values while held in reset
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Assemble and issue with the consumer always ready
    instr_ready = 1'b1;
    send_byte(8'h12);
    check("asm_lo_byte_ready", 32'(byte_ready), 32'd1);
    send_byte(8'hA5);
    exp_q.push_back(16'h12A5);
    $display("[TB] push 12A5");
    check("asm_valid", 32'(instr_valid), 32'd1);
    check("asm_out", 32'(instr_out), 32'h12A5);
    check("asm_count", 32'(count), 32'd1);
    @(posedge clk);
    #1;
    check("asm_valid_one_cycle", 32'(instr_valid), 32'd0);
    check("asm_count_after", 32'(count), 32'd0);
    instr_ready = 1'b0;

    // Fill to full, then a high byte; the low byte must be held off
    for (int i = 0; i < DEPTH; i++) send_instr(8'h10, 8'(i), 1'b0);
    check("full_count", 32'(count), 32'd8);
    send_byte(8'h20);
    check("full_lo_blocked", 32'(byte_ready), 32'd0);
    check("full_count_hold", 32'(count), 32'd8);
    instr_ready = 1'b1;
    @(posedge clk);
    #1;
    check("full_count_after_pop", 32'(count), 32'd7);
    check("full_lo_released", 32'(byte_ready), 32'd1);
    wait_drain("full_drain");
    send_byte(8'h30);
    exp_q.push_back(16'h2030);
    $display("[TB] push 2030");
    wait_drain("full_tail");

    // Simultaneous push/pop at count 3 across several pointer wraps
    for (int i = 0; i < 3; i++) send_instr(8'h30, 8'(i), 1'b0);
    check("pp_count_start", 32'(count), 32'd3);
    for (int i = 0; i < 24; i++) begin
      send_instr(8'h4A, 8'(i), 1'b1);
      check("pp_count_steady", 32'(count), 32'd3);
    end
    wait_drain("pp_drain");

    // Illegal opcode is flagged and still queued
    send_instr(8'h8F, 8'h00, 1'b0);
    check("illegal_flag", 32'(illegal_seen), 32'd1);
    check("illegal_queued", 32'(count), 32'd1);
    check("illegal_head", 32'(instr_out), 32'h8F00);

    // Flush mid-instruction; the byte offered during flush is dropped
    send_byte(8'h31);
    flush = 1'b1;
    byte_in = 8'h99;
    byte_valid = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    byte_valid = 1'b0;
    exp_q.delete();
    check("flush_count", 32'(count), 32'd0);
    check("flush_illegal", 32'(illegal_seen), 32'd0);
    check("flush_valid", 32'(instr_valid), 32'd0);
    send_instr(8'h45, 8'h67, 1'b0);
    check("flush_after_count", 32'(count), 32'd1);
    check("flush_after_head", 32'(instr_out), 32'h4567);
    wait_drain("flush_drain");

    // Asynchronous reset mid-byte-pair with a queued instruction
    send_instr(8'h8C, 8'h34, 1'b0);
    send_byte(8'h56);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check_reset_values("async_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_instr(8'h11, 8'h22, 1'b1);
    wait_drain("post_reset");

    // NOP handling depends on IFQ_NOP_DROP_EN
    instr_ready = 1'b1;
    send_instr(8'h00, 8'h55, 1'b0);
    send_instr(8'h11, 8'h22, 1'b0);
    wait_drain("nop");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Upstream feeder for the compute unit. Accepts instructions one byte at a time from the 8-bit input pins and assembles each pair of bytes into a 16-bit instruction. Buffers assembled instructions in a small FIFO and issues them to the compute unit's `instruction` input under a valid/ready handshake. Isolates the slow, byte-serial pin interface from the one-instruction-per-cycle execute stage.

## Interface
- `DEPTH`, 8, FIFO entries; power of two, ≥2. `AW = $clog2(DEPTH)` is derived.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `byte_in`  in  8  instruction byte; high byte first, then low byte.
- `byte_valid`  in  1  `byte_in` is valid this cycle.
- `byte_ready`  out  1  byte is accepted on the edge where `byte_valid && byte_ready`.
- `flush`  in  1  synchronous clear of the queue and the assembler.
- `instr_out`  out  16  FIFO head, driven to the compute unit's `instruction` input.
- `instr_valid`  out  1  head entry is valid.
- `instr_ready`  in  1  consumer takes the head on the edge where `instr_valid && instr_ready`.
- `count`  out  AW+1  number of occupied entries.
- `illegal_seen`  out  1  sticky: an instruction with opcode ≥ 4'h8 was assembled.

## Operation
- Assembler FSM has two states:
  - HI: an accepted byte is latched as `hi_byte`; go to LO.
  - LO: an accepted byte completes the instruction `{hi_byte, byte_in}`; push it to the FIFO on the same edge; go to HI.
- `byte_ready`:
  - HI: always 1.
  - LO: `count != DEPTH`.
  - It is never a function of `instr_ready`. A full FIFO blocks the low byte even when a pop happens in the same cycle.
- Instruction fields are `opcode[15:12]`, `tgt[11:8]`, `src0[7:4]`, `src1[3:0]`, `imm[7:0]`. This block does not modify any field.
- Issue:
  - `instr_valid = (count != 0)`.
  - `instr_out` is the entry at the read pointer.
  - A pop advances the read pointer.
- Simultaneous push and pop: both complete; `count` is unchanged.
- Pointers are AW bits wide and wrap modulo DEPTH. Full and empty are distinguished only by `count`.
- `illegal_seen` is set when a completed instruction has `opcode[3] == 1`. That instruction is still queued; the compute unit executes it as a no-op.
- `flush` has priority over push, pop and byte acceptance in the same cycle. On the next edge:
  - pointers = 0 and `count` = 0;
  - FSM = HI and any partial `hi_byte` is discarded;
  - `illegal_seen` = 0.
  - A byte presented during a flush cycle is dropped, even if `byte_ready` = 1.
- Reset (asynchronous, may occur mid-instruction):
  - FSM = HI, `hi_byte` = 0, pointers = 0, storage = 0;
  - `count` = 0, `byte_ready` = 1, `instr_valid` = 0, `instr_out` = 16'h0000, `illegal_seen` = 0.

## Timing
- Low byte accepted at edge N → `instr_valid` = 1 and `instr_out` holds the instruction after edge N, when the FIFO was empty. There is no bypass path; minimum latency is 1 cycle.
- Byte throughput is one byte per cycle, so the peak rate is one instruction per 2 cycles.
- Drain rate is one instruction per cycle while `instr_ready` = 1.
- `instr_out` must hold stable while `instr_valid && !instr_ready`.
- All outputs are registered or decoded directly from registered state. There is no combinational path from any input to any output.

## Configuration
- `IFQ_NOP_DROP_EN`:
  - Defined: a completed instruction with `opcode == 4'h0` (NOP) is not pushed. The FSM still returns to HI and `count` is unchanged. `byte_ready` rules are unchanged, so a low byte completing a NOP is still held off while the FIFO is full.
  - Undefined: NOPs are queued and issued like any other instruction.

## Structure
- Shared package `ifq_pkg`:
  - opcode constants `OP_NOP`=0, `OP_LOAD`=1, `OP_ADD`=2, `OP_SUB`=3, `OP_AND`=4, `OP_OR`=5, `OP_NOT`=6, `OP_XOR`=7;
  - instruction field bit-position constants;
  - the assembler state enum.
- The compute unit uses the same package.
- One sub-module, `ifq_fifo`: storage, pointers, count, push/pop/flush. It is parameterised by DEPTH and width 16.
- Assembler FSM and `illegal_seen` live in the top level.

## Test plan
- **Assemble and issue:** with `instr_ready` = 1, send bytes 0x12, 0xA5 → `instr_out` = 16'h12A5 with `instr_valid` high for exactly one cycle, one cycle after the 0xA5 edge; `count` 1 → 0.
- **Fill to full:** with `instr_ready` = 0 and DEPTH = 8, send 8 instructions 0x1000–0x1007, then a high byte 0x20 → `count` = 8. The high byte is accepted and `byte_ready` drops to 0 in LO. Raise `instr_ready` → issue order is 0x1000 … 0x1007, then `byte_ready` = 1.
- **Simultaneous push/pop:** with `count` = 3, complete a push in the same cycle as a pop → `count` stays 3 and order is preserved across pointer wrap (run ≥ 20 instructions).
- **Flush mid-instruction:** send high byte 0x31, assert `flush`, then send 0x45, 0x67 → the only instruction issued is 16'h4567; `count` = 1.
- **Illegal and reset:** send 0x8F, 0x00 → `illegal_seen` = 1 and 0x8F00 is queued. Assert `rst_n` = 0 asynchronously mid-byte-pair → all outputs take their reset values immediately.
- **`IFQ_NOP_DROP_EN`:** send 0x00, 0x55 then 0x11, 0x22 → defined: only 16'h1122 issues; undefined: 16'h0055 then 16'h1122.
